// File: rtl/des_decrypt_key_schedule.sv
// DES key schedule for decryption: PC-1 loads C/D once, then right rotations
// walk the schedule backwards so K16..K1 are presented one per handshake.
module des_decrypt_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key_in,
    input  logic        subkey_ready,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    output logic [3:0]  round_num,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE, EMIT} state_t;

    // FIPS 46-3 selection tables, 1-based with bit 1 as the MSB.
    localparam int PC1_TAB [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic        rot_one;
    logic        accept;
    logic        unused_parity;

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55-i] = k[64-PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[47-i] = cd[56-PC2_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [27:0] ror(input logic [27:0] v, input logic one);
        return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    // Parity bits (FIPS 8, 16, ..., 64) take no part in the schedule.
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8], key_in[0]};

    // Single-bit rotations mirror encrypt rounds 16, 9 and 2.
    assign rot_one = (round_num == 4'd0) || (round_num == 4'd7) || (round_num == 4'd14);

    assign subkey_valid = (state == EMIT);
    assign busy         = (state != IDLE);
    assign accept       = subkey_valid && subkey_ready;
    assign subkey       = pc2({c_reg, d_reg});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            c_reg     <= '0;
            d_reg     <= '0;
            round_num <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        {c_reg, d_reg} <= pc1(key_in);
                        round_num      <= '0;
                        state          <= EMIT;
                    end
                end
                EMIT: begin
                    if (accept) begin
                        if (round_num == 4'd15) begin
                            state     <= IDLE;
                            done      <= 1'b1;
                            round_num <= '0;
                        end else begin
                            c_reg     <= ror(c_reg, rot_one);
                            d_reg     <= ror(d_reg, rot_one);
                            round_num <= round_num + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// Bench for des_decrypt_key_schedule: expected {round_num, subkey} pairs are
// queued by the driver and consumed by a monitor on each presented subkey.
module tb_des_decrypt_key_schedule;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_num;
    logic        busy;
    logic        done;

    des_decrypt_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_in       (key_in),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_num    (round_num),
        .busy         (busy),
        .done         (done)
    );

    // Encryption-order subkeys K1..K16 for key 133457799BBCDFF1.
    localparam logic [47:0] K_ENC [0:15] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic [51:0] exp_q[$];
    int          n_vec;
    int          n_err;
    int          done_cnt;
    logic        rand_ready;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ready generator ----------------
    initial begin
        subkey_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            subkey_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                check("done_with_valid", {63'd0, subkey_valid}, 64'd0);
            end
            if (subkey_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_subkey: got %h expected none at %0t", subkey, $time);
                end else begin
                    check("subkey", {16'd0, subkey}, {16'd0, exp_q[0][47:0]});
                    check("round_num", {60'd0, round_num}, {60'd0, exp_q[0][51:48]});
                    if (subkey_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    // sel: 0 = reference table, 1 = all zeros, 2 = all ones.
    // inject: 0 = none, 1 = start with another key at round 5, 2 = reset at round 9.
    task automatic run_sched(input logic [63:0] key, input int sel, input int inject);
        int          n;
        int          done_before;
        logic        injected;
        logic        aborted;
        logic [47:0] ks;
        injected = 1'b0;
        aborted  = 1'b0;
        for (int r = 0; r < 16; r++) begin
            ks = (sel == 0) ? K_ENC[15-r] : (sel == 1) ? 48'h0 : {48{1'b1}};
            exp_q.push_back({4'(r), ks});
        end
        done_before = done_cnt;
        @(posedge clk);
        #1;
        key_in = key;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = ~key;
        n = 0;
        while (!done && n < 400 && !aborted) begin
            if (inject == 1 && !injected && subkey_valid && round_num == 4'd5) begin
                start    = 1'b1;
                key_in   = 64'h0;
                injected = 1'b1;
            end
            if (inject == 2 && subkey_valid && round_num == 4'd9) begin
                #2;
                rst = 1'b1;
                #1;
                check("rst_valid", {63'd0, subkey_valid}, 64'd0);
                check("rst_busy", {63'd0, busy}, 64'd0);
                check("rst_round", {60'd0, round_num}, 64'd0);
                check("rst_subkey", {16'd0, subkey}, 64'd0);
                exp_q.delete();
                @(posedge clk);
                #1;
                rst = 1'b0;
                aborted = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                start = 1'b0;
                n++;
            end
        end
        if (aborted) begin
            repeat (20) @(posedge clk);
            #1;
            check("no_done_after_rst", 64'(done_cnt), 64'(done_before));
        end else begin
            check("done_timeout", {63'd0, (n >= 400)}, 64'd0);
            if (!rand_ready) check("done_latency", 64'(n), 64'd16);
            @(posedge clk);
            #1;
            check("done_pulse_width", {63'd0, done}, 64'd0);
            check("busy_after_done", {63'd0, busy}, 64'd0);
            check("done_count", 64'(done_cnt), 64'(done_before + 1));
            check("queue_drained", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        done_cnt   = 0;
        rand_ready = 1'b0;
        rst        = 1'b1;
        start      = 1'b0;
        key_in     = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_valid", {63'd0, subkey_valid}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_round", {60'd0, round_num}, 64'd0);
        check("reset_subkey", {16'd0, subkey}, 64'd0);

        run_sched(64'h133457799BBCDFF1, 0, 0);
        rand_ready = 1'b1;
        run_sched(64'h133457799BBCDFF1, 0, 0);
        run_sched(64'h123556789ABDDEF0, 0, 0);
        rand_ready = 1'b0;
        run_sched(64'h0000000000000000, 1, 0);
        run_sched(64'h0101010101010101, 1, 0);
        run_sched(64'hFEFEFEFEFEFEFEFE, 2, 0);
        run_sched(64'h133457799BBCDFF1, 0, 1);
        run_sched(64'hFEFEFEFEFEFEFEFE, 2, 0);
        run_sched(64'h133457799BBCDFF1, 0, 2);
        run_sched(64'h133457799BBCDFF1, 0, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
